// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, width and legality helper
package alu_pkg;
    localparam int ALU_WIDTH = 32;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    typedef enum logic {RSP_EMPTY, RSP_FULL} rsp_state_t;
    function automatic logic alu_op_legal(input logic [3:0] op);
        return op inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT};
    endfunction
endpackage

// File: rtl/alu.sv
// alu: 32-bit MIPS ALU, illegal control codes yield a zero result
module alu
    import alu_pkg::*;
(
    input  logic [ALU_WIDTH-1:0] read1,
    input  logic [ALU_WIDTH-1:0] read2,
    input  logic [3:0]           control,
    output logic [ALU_WIDTH-1:0] result,
    output logic                 zero
);
    // select the operation result by control code
    always_comb begin
        result = control == ALU_AND ? read1 & read2 :
                 control == ALU_OR  ? read1 | read2 :
                 control == ALU_ADD ? read1 + read2 :
                 control == ALU_SUB ? read1 - read2 :
                 control == ALU_SLT ? {{(ALU_WIDTH-1){1'b0}}, $signed(read1) < $signed(read2)} :
                 '0;
        zero = result == '0;
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters with a registered response
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err
);
    rsp_state_t       r_state;
    rsp_state_t       w_state_next;
    logic             r_last;
    logic             r_id;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_err;
    logic             w_slot_free;
    logic             w_gnt1;
    logic             w_accept;
    logic             w_legal;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [3:0]       w_op;
    logic [WIDTH-1:0] w_result;
    logic             w_zero;

    assign rsp_valid   = r_state == RSP_FULL;
    assign w_slot_free = (!rsp_valid || rsp_ready) && !reset;
    // requester 1 wins when alone, or when both ask and requester 0 went last
    assign w_gnt1      = req1_valid && (!req0_valid || !r_last);
    assign req1_ready  = w_slot_free && w_gnt1;
    assign req0_ready  = w_slot_free && req0_valid && !w_gnt1;
    assign w_accept    = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    // idle cycles feed requester 0 so the ALU never sees X from the mux
    assign w_a         = req1_ready ? req1_a  : req0_a;
    assign w_b         = req1_ready ? req1_b  : req0_b;
    assign w_op        = req1_ready ? req1_op : req0_op;
    assign w_legal     = alu_op_legal(w_op);
    assign rsp_id      = r_id;
    assign rsp_result  = r_result;
    assign rsp_zero    = r_zero;
    assign rsp_err     = r_err;

    alu u_alu (
        .read1   (w_a),
        .read2   (w_b),
        .control (w_op),
        .result  (w_result),
        .zero    (w_zero)
    );

    // response slot state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= RSP_EMPTY;
        else       r_state <= w_state_next;
    end

    // fill on accept, drain when the consumer takes it without a refill
    always_comb begin
        w_state_next = w_accept ? RSP_FULL : rsp_ready ? RSP_EMPTY : r_state;
    end

    // capture the ALU outputs and owner on every accept
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last   <= 1'b1;
            r_id     <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_last   <= req1_ready;
            r_id     <= req1_ready;
            r_result <= w_result;
            r_zero   <= w_zero && w_legal;
            r_err    <= !w_legal;
        end
    end
endmodule
